// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between LSU requesters.
// Optional MEM_ARB_STATS_EN adds saturating grant and busy-cycle counters.
//   state      | meaning
//   IDLE       | scanning requesters from rr_ptr for the next grant
//   READ_WAIT  | read issued to memory, waiting for mem_read_ready
//   WRITE_WAIT | write issued to memory, waiting for mem_write_ready
//   RELAY      | response held until the granted requester drops its valid
module lsu_mem_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQUESTERS-1:0]                 req_read_valid,
  input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0]  req_read_address,
  output logic [NUM_REQUESTERS-1:0]                 req_read_ready,
  output logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0]  req_read_data,
  input  logic [NUM_REQUESTERS-1:0]                 req_write_valid,
  input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0]  req_write_address,
  input  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0]  req_write_data,
  output logic [NUM_REQUESTERS-1:0]                 req_write_ready,
  output logic                                      mem_read_valid,
  output logic [ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                      mem_read_ready,
  input  logic [DATA_BITS-1:0]                      mem_read_data,
  output logic                                      mem_write_valid,
  output logic [ADDR_BITS-1:0]                      mem_write_address,
  output logic [DATA_BITS-1:0]                      mem_write_data,
  input  logic                                      mem_write_ready
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]                               stat_grants,
  output logic [31:0]                               stat_busy_cycles
`endif
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] grant_idx, grant_nxt, rr_ptr, rr_nxt, scan_idx, pick;
  logic grant_is_read, is_read_nxt, found;
  logic mrv_nxt, mwv_nxt;
  logic [ADDR_BITS-1:0] mra_nxt, mwa_nxt;
  logic [DATA_BITS-1:0] mwd_nxt;
  logic [NUM_REQUESTERS-1:0] rrdy_nxt, wrdy_nxt;
  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] rdata_nxt;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQUESTERS) s = s - NUM_REQUESTERS;
    return IDX_W'(s);
  endfunction

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_idx;
    rr_nxt      = rr_ptr;
    is_read_nxt = grant_is_read;
    mrv_nxt     = mem_read_valid;
    mra_nxt     = mem_read_address;
    mwv_nxt     = mem_write_valid;
    mwa_nxt     = mem_write_address;
    mwd_nxt     = mem_write_data;
    rrdy_nxt    = req_read_ready;
    wrdy_nxt    = req_write_ready;
    rdata_nxt   = req_read_data;
    found       = 1'b0;
    pick        = '0;
    scan_idx    = '0;

    // First requester with any valid, starting at rr_ptr.
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      scan_idx = wrap_idx(rr_ptr, k);
      if (!found && (req_read_valid[scan_idx] || req_write_valid[scan_idx])) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          rr_nxt    = wrap_idx(pick, 1);
          if (req_read_valid[pick]) begin
            is_read_nxt = 1'b1;
            mrv_nxt     = 1'b1;
            mra_nxt     = req_read_address[pick];
            state_nxt   = READ_WAIT;
          end else begin
            is_read_nxt = 1'b0;
            mwv_nxt     = 1'b1;
            mwa_nxt     = req_write_address[pick];
            mwd_nxt     = req_write_data[pick];
            state_nxt   = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mrv_nxt              = 1'b0;
          rdata_nxt[grant_idx] = mem_read_data;
          rrdy_nxt[grant_idx]  = 1'b1;
          state_nxt            = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mwv_nxt             = 1'b0;
          wrdy_nxt[grant_idx] = 1'b1;
          state_nxt           = RELAY;
        end
      end
      RELAY: begin
        if (grant_is_read && !req_read_valid[grant_idx]) begin
          rrdy_nxt[grant_idx] = 1'b0;
          state_nxt           = IDLE;
        end else if (!grant_is_read && !req_write_valid[grant_idx]) begin
          wrdy_nxt[grant_idx] = 1'b0;
          state_nxt           = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      grant_idx         <= '0;
      rr_ptr            <= '0;
      grant_is_read     <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      req_read_ready    <= '0;
      req_write_ready   <= '0;
      req_read_data     <= '0;
    end else begin
      state             <= state_nxt;
      grant_idx         <= grant_nxt;
      rr_ptr            <= rr_nxt;
      grant_is_read     <= is_read_nxt;
      mem_read_valid    <= mrv_nxt;
      mem_read_address  <= mra_nxt;
      mem_write_valid   <= mwv_nxt;
      mem_write_address <= mwa_nxt;
      mem_write_data    <= mwd_nxt;
      req_read_ready    <= rrdy_nxt;
      req_write_ready   <= wrdy_nxt;
      req_read_data     <= rdata_nxt;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grants      <= '0;
      stat_busy_cycles <= '0;
    end else begin
      if (state == IDLE && found && stat_grants != 32'hFFFF_FFFF)
        stat_grants <= stat_grants + 32'd1;
      if (state != IDLE && stat_busy_cycles != 32'hFFFF_FFFF)
        stat_busy_cycles <= stat_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: vector table plus hand-written multi-cycle sequences.
// Stats counters are checked when MEM_ARB_STATS_EN is defined.
module tb_lsu_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] rv, wv;
  logic [3:0][7:0] ra, wa, wd;
  logic [3:0] req_read_ready, req_write_ready;
  logic [3:0][7:0] req_read_data;
  logic mem_read_valid, mem_write_valid, mem_read_ready, mem_write_ready;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_grants, stat_busy_cycles;
`endif

  lsu_mem_arbiter #(.NUM_REQUESTERS(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req_read_valid(rv), .req_read_address(ra),
    .req_read_ready(req_read_ready), .req_read_data(req_read_data),
    .req_write_valid(wv), .req_write_address(wa), .req_write_data(wd),
    .req_write_ready(req_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_busy_cycles(stat_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 3;
  bit inj_rd = 1'b0, inj_wr = 1'b0;
  logic [7:0] mem_img [256];

  // Memory model: answers lat cycles after it first sees a valid; runs after the bench drives.
  initial begin
    int rcnt, wcnt;
    rcnt = 0; wcnt = 0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'h00;
    forever begin
      @(posedge clk); #2;
      mem_read_ready  = inj_rd;
      mem_write_ready = inj_wr;
      if (mem_read_valid) begin
        rcnt++;
        if (rcnt == lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_img[mem_read_address];
        end
      end else rcnt = 0;
      if (mem_write_valid) begin
        wcnt++;
        if (wcnt == lat) begin
          mem_write_ready = 1'b1;
          mem_img[mem_write_address] = mem_write_data;
        end
      end else wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int kind, input int idx);
    case (kind)
      0:       return mem_read_valid;
      1:       return mem_write_valid;
      2:       return req_read_ready[idx];
      default: return req_write_ready[idx];
    endcase
  endfunction

  task automatic wait_for(input string name, input int kind, input int idx, output int n);
    n = 0;
    while (!sig(kind, idx) && n < 40) begin
      tick();
      n++;
    end
    if (!sig(kind, idx)) begin
      checks++;
      errors++;
      $display("FAIL %s: still low after %0d cycles, required high", name, n);
    end
  endtask

  typedef struct packed {
    logic [1:0] rid;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] lat;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic do_vec(input vec_t v);
    int r, n;
    r = int'(v.rid);
    lat = int'(v.lat);
    if (v.wr) begin
      wv[r] = 1'b1; wa[r] = v.addr; wd[r] = v.wdata;
    end else begin
      rv[r] = 1'b1; ra[r] = v.addr;
    end
    tick();
    if (v.wr) begin
      chk("wr_issue", mem_write_valid, 1);
      chk("wr_no_read", mem_read_valid, 0);
      chk("wr_addr", mem_write_address, v.addr);
      chk("wr_data", mem_write_data, v.wdata);
      wait_for("wr_ready", 3, r, n);
      chk("wr_latency", n, lat);
      chk("mem_wv_drop", mem_write_valid, 0);
      wv[r] = 1'b0;
      tick();
      chk("wr_ready_clear", req_write_ready[r], 0);
    end else begin
      chk("rd_issue", mem_read_valid, 1);
      chk("rd_no_write", mem_write_valid, 0);
      chk("rd_addr", mem_read_address, v.addr);
      wait_for("rd_ready", 2, r, n);
      chk("rd_latency", n, lat);
      chk("rd_data", req_read_data[r], v.exp_rdata);
      chk("mem_rv_drop", mem_read_valid, 0);
      rv[r] = 1'b0;
      tick();
      chk("rd_ready_clear", req_read_ready[r], 0);
      chk("rd_data_hold", req_read_data[r], v.exp_rdata);
    end
    tick();
  endtask

  initial begin
    int gnt [5];
    int exp_gnt [5];
    logic [7:0] exp_t2 [4];
    int gcount, done, cyc, n;
    logic prev;

    for (int a = 0; a < 256; a++) mem_img[a] = ~8'(a);
    mem_img[8'h12] = 8'hA5;

    //            rid   wr    addr   wdata  lat   exp
    vecs[0] = {2'd0, 1'b0, 8'h12, 8'h00, 4'd3, 8'hA5};
    vecs[1] = {2'd2, 1'b1, 8'h40, 8'h3C, 4'd2, 8'h00};
    vecs[2] = {2'd3, 1'b0, 8'h40, 8'h00, 4'd1, 8'h3C};
    vecs[3] = {2'd1, 1'b1, 8'hFF, 8'h81, 4'd4, 8'h00};
    vecs[4] = {2'd0, 1'b0, 8'hFF, 8'h00, 4'd2, 8'h81};
    vecs[5] = {2'd2, 1'b0, 8'h00, 8'h00, 4'd1, 8'hFF};
    vecs[6] = {2'd1, 1'b0, 8'h07, 8'h00, 4'd3, 8'hF8};

    reset = 1'b0; rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    tick(); tick();
    chk("rst_mem_rv", mem_read_valid, 0);
    chk("rst_mem_wv", mem_write_valid, 0);
    chk("rst_rdata", req_read_data, 0);
    @(negedge clk); reset = 1'b1;
    tick();
    chk("idle_no_req", {mem_read_valid, mem_write_valid, req_read_ready, req_write_ready}, 0);

    // Round-robin among four continuous readers.
    exp_gnt[0] = 0; exp_gnt[1] = 1; exp_gnt[2] = 2; exp_gnt[3] = 3; exp_gnt[4] = 0;
    exp_t2[0] = 8'hEF; exp_t2[1] = 8'hDE; exp_t2[2] = 8'hCD; exp_t2[3] = 8'hBC;
    for (int i = 0; i < 5; i++) gnt[i] = -1;
    lat = 3;
    ra[0] = 8'h10; ra[1] = 8'h21; ra[2] = 8'h32; ra[3] = 8'h43;
    rv = 4'hF;
    gcount = 0; done = 0; cyc = 0; prev = 1'b0;
    while (done < 5 && cyc < 200) begin
      tick();
      cyc++;
      if (mem_read_valid && !prev && gcount < 5) begin
        for (int i = 0; i < 4; i++)
          if (mem_read_address == ra[i]) gnt[gcount] = i;
        gcount++;
      end
      prev = mem_read_valid;
      for (int i = 0; i < 4; i++) begin
        if (rv[i] && req_read_ready[i]) begin
          chk("rr_data", req_read_data[i], exp_t2[i]);
          rv[i] = 1'b0;
          done++;
        end else if (!rv[i] && !req_read_ready[i] && gcount < 5) begin
          rv[i] = 1'b1;
        end
      end
      if (done == 5) rv = '0;
    end
    chk("rr_completions", done, 5);
    for (int i = 0; i < 5; i++) chk("rr_grant_order", gnt[i], exp_gnt[i]);
    tick(); tick();
`ifdef MEM_ARB_STATS_EN
    chk("stat_grants", stat_grants, 5);
    chk("stat_busy_cycles", stat_busy_cycles, 20);
`endif

    for (int i = 0; i < 7; i++) do_vec(vecs[i]);

    // Memory ready pulses while idle must be ignored.
    inj_rd = 1'b1; inj_wr = 1'b1;
    tick();
    inj_rd = 1'b0; inj_wr = 1'b0;
    tick(); tick();
    chk("stray_ready_idle", {mem_read_valid, mem_write_valid, req_read_ready, req_write_ready}, 0);

    // Stray mem_write_ready during a read wait.
    inj_wr = 1'b1;
    do_vec({2'd3, 1'b0, 8'h21, 8'h00, 4'd3, 8'hDE});
    inj_wr = 1'b0;
    chk("stray_wr_ready_in_read", req_write_ready, 0);

    // Read and write together: read first, write on a later grant.
    lat = 2;
    rv[1] = 1'b1; ra[1] = 8'h21;
    wv[1] = 1'b1; wa[1] = 8'h50; wd[1] = 8'h77;
    tick();
    chk("rw_read_first", mem_read_valid, 1);
    chk("rw_write_held", mem_write_valid, 0);
    chk("rw_read_addr", mem_read_address, 8'h21);
    wait_for("rw_rd_ready", 2, 1, n);
    chk("rw_rd_data", req_read_data[1], 8'hDE);
    rv[1] = 1'b0;
    wait_for("rw_wr_issue", 1, 0, n);
    chk("rw_wr_addr", mem_write_address, 8'h50);
    chk("rw_wr_data", mem_write_data, 8'h77);
    wait_for("rw_wr_ready", 3, 1, n);
    wv[1] = 1'b0;
    tick(); tick();
    chk("rw_mem_77", mem_img[8'h50], 8'h77);

    // Asynchronous reset in the middle of a read wait.
    lat = 15;
    rv[0] = 1'b1; ra[0] = 8'h12;
    tick();
    chk("ar_issue", mem_read_valid, 1);
    tick();
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("ar_mem_rv", mem_read_valid, 0);
    chk("ar_mem_wv", mem_write_valid, 0);
    chk("ar_mem_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
    chk("ar_ready", {req_read_ready, req_write_ready}, 0);
    chk("ar_rdata", req_read_data, 0);
    rv = '0;
    @(negedge clk); reset = 1'b1;
    lat = 2;
    tick();
    rv[0] = 1'b1; ra[0] = 8'h12;
    rv[1] = 1'b1; ra[1] = 8'h33;
    tick();
    chk("ar_first_req0", mem_read_address, 8'h12);
    wait_for("ar_rd_ready", 2, 0, n);
    chk("ar_rd_data", req_read_data[0], 8'hA5);
    rv[0] = 1'b0;
    wait_for("ar_req1_ready", 2, 1, n);
    chk("ar_req1_data", req_read_data[1], 8'hCC);
    rv[1] = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
